// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between display reads (strict priority) and a loader port
module bram_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 1023
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic              ld_gnt_o,
  output logic [DATA_W-1:0] ld_rdata_o,
  output logic              ld_rvalid_o,
  output logic              ld_starve_o,
  output logic              bram_en_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_din_o,
  input  logic [DATA_W-1:0] bram_dout_i
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {L_IDLE, L_WAIT, L_GNT} ld_state_e;
  ld_state_e state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic bram_en_q, bram_en_d, bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;
  // Read-return tag {valid, owner}; owner 1 marks a loader read
  logic [1:0] tag_q [0:RD_LATENCY];
  logic [1:0] tag_d;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= L_IDLE;
    else state_q <= state_d;

  always_comb
    state_d = state_q == L_IDLE ? (ld_req_i ? L_WAIT : L_IDLE) :
              state_q == L_WAIT ? (!ld_req_i ? L_IDLE : disp_req_i ? L_WAIT : L_GNT) :
              L_IDLE;

  always_comb ld_gnt_o = state_q == L_WAIT && ld_req_i && !disp_req_i;

  always_comb begin
    bram_en_d   = disp_req_i | ld_gnt_o;
    bram_we_d   = ld_gnt_o & ld_we_i;
    bram_addr_d = disp_req_i ? disp_addr_i : ld_gnt_o ? ld_addr_i : bram_addr_q;
    bram_din_d  = ld_gnt_o ? ld_wdata_i : bram_din_q;
    tag_d       = {disp_req_i | (ld_gnt_o & ~ld_we_i), ~disp_req_i};
    wait_d      = (state_q != L_WAIT || ld_gnt_o) ? '0 :
                  wait_q == CW'(MAX_WAIT) ? wait_q : wait_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      wait_q      <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      wait_q      <= wait_d;
      tag_q[0]    <= tag_d;
      for (int i = 1; i <= RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end

  assign bram_en_o    = bram_en_q;
  assign bram_we_o    = bram_we_q;
  assign bram_addr_o  = bram_addr_q;
  assign bram_din_o   = bram_din_q;
  assign disp_data_o  = bram_dout_i;
  assign ld_rdata_o   = bram_dout_i;
  assign disp_valid_o = tag_q[RD_LATENCY][1] & ~tag_q[RD_LATENCY][0];
  assign ld_rvalid_o  = tag_q[RD_LATENCY][1] & tag_q[RD_LATENCY][0];
  assign ld_starve_o  = wait_q == CW'(MAX_WAIT);
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: scoreboard bench driving two arbiters (read latency 1 and 2) in lockstep
module tb_bram_port_arbiter;
  localparam int LA = 1, LB = 2, MW = 4;
  typedef struct {logic [11:0] d; int c;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic disp_req = 1'b0, ld_req = 1'b0, ld_we = 1'b0;
  logic [16:0] disp_addr = '0, ld_addr = '0;
  logic [11:0] ld_wdata = '0;
  logic [11:0] ddata_a, rdata_a, din_a, dout_a, r1_a;
  logic [11:0] ddata_b, rdata_b, din_b, dout_b, r1_b, r2_b;
  logic [16:0] addr_a, addr_b;
  logic dvalid_a, rvalid_a, gnt_a, starve_a, en_a, we_a;
  logic dvalid_b, rvalid_b, gnt_b, starve_b, en_b, we_b;
  logic [11:0] mem_a [int];
  logic [11:0] mem_b [int];
  int cyc = 0, checks = 0, errors = 0;
  exp_t qd_a[$], ql_a[$], qd_b[$], ql_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_arbiter #(.RD_LATENCY(LA), .MAX_WAIT(MW)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_data_o(ddata_a), .disp_valid_o(dvalid_a), .ld_req_i(ld_req), .ld_we_i(ld_we),
    .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_gnt_o(gnt_a), .ld_rdata_o(rdata_a),
    .ld_rvalid_o(rvalid_a), .ld_starve_o(starve_a), .bram_en_o(en_a), .bram_we_o(we_a),
    .bram_addr_o(addr_a), .bram_din_o(din_a), .bram_dout_i(dout_a));

  bram_port_arbiter #(.RD_LATENCY(LB), .MAX_WAIT(MW)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_data_o(ddata_b), .disp_valid_o(dvalid_b), .ld_req_i(ld_req), .ld_we_i(ld_we),
    .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_gnt_o(gnt_b), .ld_rdata_o(rdata_b),
    .ld_rvalid_o(rvalid_b), .ld_starve_o(starve_b), .bram_en_o(en_b), .bram_we_o(we_b),
    .bram_addr_o(addr_b), .bram_din_o(din_b), .bram_dout_i(dout_b));

  // BRAM models: unwritten locations read as addr+0x100
  always @(posedge clk) begin
    if (en_a && we_a) mem_a[int'(addr_a)] = din_a;
    if (en_a && !we_a) r1_a <= mem_a.exists(int'(addr_a)) ? mem_a[int'(addr_a)] : 12'(addr_a) + 12'h100;
    if (en_b && we_b) mem_b[int'(addr_b)] = din_b;
    if (en_b && !we_b) r1_b <= mem_b.exists(int'(addr_b)) ? mem_b[int'(addr_b)] : 12'(addr_b) + 12'h100;
    r2_b <= r1_b;
  end
  assign dout_a = r1_a;
  assign dout_b = r2_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: valid=1 with nothing outstanding, required 0 at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_d(input logic [11:0] d, input int t);
    qd_a.push_back('{d, t + 1 + LA});
    qd_b.push_back('{d, t + 1 + LB});
  endtask

  task automatic push_l(input logic [11:0] d, input int g);
    ql_a.push_back('{d, g + 1 + LA});
    ql_b.push_back('{d, g + 1 + LB});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dvalid_a) begin
      if (qd_a.size() == 0) unexpected("a_disp_valid");
      else begin e = qd_a.pop_front(); chk("a_disp_data", 32'(ddata_a), 32'(e.d)); chk("a_disp_cycle", cyc, e.c); end
    end
    if (rvalid_a) begin
      if (ql_a.size() == 0) unexpected("a_ld_rvalid");
      else begin e = ql_a.pop_front(); chk("a_ld_rdata", 32'(rdata_a), 32'(e.d)); chk("a_ld_cycle", cyc, e.c); end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (dvalid_b) begin
      if (qd_b.size() == 0) unexpected("b_disp_valid");
      else begin e = qd_b.pop_front(); chk("b_disp_data", 32'(ddata_b), 32'(e.d)); chk("b_disp_cycle", cyc, e.c); end
    end
    if (rvalid_b) begin
      if (ql_b.size() == 0) unexpected("b_ld_rvalid");
      else begin e = ql_b.pop_front(); chk("b_ld_rdata", 32'(rdata_b), 32'(e.d)); chk("b_ld_cycle", cyc, e.c); end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_a_ctl"}, 32'({en_a, we_a, gnt_a, dvalid_a, rvalid_a, starve_a}), 32'd0);
    chk({tag, "_a_addr"}, 32'(addr_a), 32'd0);
    chk({tag, "_a_din"}, 32'(din_a), 32'd0);
    chk({tag, "_b_ctl"}, 32'({en_b, we_b, gnt_b, dvalid_b, rvalid_b, starve_b}), 32'd0);
    chk({tag, "_b_addr"}, 32'(addr_b), 32'd0);
    chk({tag, "_b_din"}, 32'(din_b), 32'd0);
  endtask

  task automatic chk_starve(input logic exp);
    chk("a_starve", 32'(starve_a), 32'(exp));
    chk("b_starve", 32'(starve_b), 32'(exp));
  endtask

  // Loader access; gap is the hand-computed number of cycles from request to grant
  task automatic ld_op(input logic we, input logic [16:0] a, input logic [11:0] d, input int gap);
    int t0, ga, gb;
    t0 = cyc; ga = -1; gb = -1;
    ld_req = 1'b1; ld_we = we; ld_addr = a; ld_wdata = d;
    if (!we) push_l(d, t0 + gap);
    for (int k = 0; k < 64 && (ga < 0 || gb < 0); k++) begin
      @(negedge clk);
      if (gnt_a && ga < 0) ga = cyc - t0;
      if (gnt_b && gb < 0) gb = cyc - t0;
    end
    chk("a_gnt_gap", ga, gap);
    chk("b_gnt_gap", gb, gap);
    tick();
    ld_req = 1'b0;
  endtask

  initial begin
    logic bad;
    repeat (3) tick();
    chk_idle("rst");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      disp_req = 1'b1; disp_addr = 17'(i);
      push_d(12'h100 + 12'(i), cyc);
      tick();
    end
    disp_req = 1'b0;
    repeat (4) tick();
    ld_op(1'b1, 17'h1FFFF, 12'hABC, 1);
    chk("a_bram_wr", 32'({en_a, we_a}), 32'd3);
    chk("a_bram_addr", 32'(addr_a), 32'h1FFFF);
    chk("a_bram_din", 32'(din_a), 32'hABC);
    chk("b_bram_wr", 32'({en_b, we_b}), 32'd3);
    chk("b_bram_addr", 32'(addr_b), 32'h1FFFF);
    chk("b_bram_din", 32'(din_b), 32'hABC);
    tick();
    ld_op(1'b0, 17'h1FFFF, 12'hABC, 1);
    repeat (4) tick();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          disp_req = 1'b1; disp_addr = 17'(32 + i);
          push_d(12'h120 + 12'(i), cyc);
          if (i == 4) chk_starve(1'b0);
          if (i == 5 || i == 19) chk_starve(1'b1);
          tick();
        end
        disp_req = 1'b0;
        tick();
        chk_starve(1'b0);
      end
      ld_op(1'b0, 17'd5, 12'h105, 20);
    join
    repeat (4) tick();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          disp_req = (i % 2 == 0); disp_addr = 17'(3 + i / 2);
          if (i % 2 == 0) push_d(12'h103 + 12'(i / 2), cyc);
          tick();
        end
        disp_req = 1'b0;
      end
      begin
        ld_op(1'b0, 17'd9, 12'h109, 1);
        ld_op(1'b0, 17'h1FFFF, 12'hABC, 3);
      end
    join
    repeat (6) tick();
    disp_req = 1'b1; disp_addr = 17'd2;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 17'd7;
    tick();
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    disp_req = 1'b0; ld_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < LB + 2; k++) begin
      tick();
      bad |= en_a | en_b | gnt_a | gnt_b | dvalid_a | dvalid_b | rvalid_a | rvalid_b;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    chk("a_drain", qd_a.size() + ql_a.size(), 0);
    chk("b_drain", qd_b.size() + ql_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
